// File: rtl/eth_pkg.sv
// Shared types and entry-layout helpers for the N-channel TX arbiter.
// Entry layout is {user, last, keep, data}, LSB first from data.
package eth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_FLUSH = 2'd2
    } txarb_state_t;

    localparam int DATA_LSB = 0;

    function automatic int keep_lsb(int dw);
        return dw;
    endfunction

    function automatic int last_bit(int dw);
        return dw + dw / 8;
    endfunction

    function automatic int user_bit(int dw);
        return dw + dw / 8 + 1;
    endfunction

    // {user, last} of the watchdog terminator; keep and data are zero.
    localparam logic [1:0] TERM_UL = 2'b11;

endpackage

// File: rtl/eth_rr_pick.sv
// Combinational round-robin picker: first requester after ptr, wrapping.
// Ids at or above NCH are never produced.
module eth_rr_pick
#(
    parameter int NCH  = 2,
    parameter int ID_W = 1
)(
    input  logic [NCH-1:0]  req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] grant,
    output logic            found
);

    logic [ID_W-1:0] idx;

    // Scan ptr+1 .. ptr+NCH modulo NCH, keep the first hit.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NCH; k++) begin
            idx = ID_W'((int'(ptr) + k) % NCH);
            if (!found && req[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/eth_txarb_n.sv
// Packet-atomic N-channel round-robin merger with stalled-packet watchdog.
// Define TXARB_STATS_EN to build the per-channel packet counters.
module eth_txarb_n
    import eth_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int DATA_W  = 64,
    parameter int KEEP_W  = DATA_W / 8,
    parameter int ENT_W   = DATA_W + KEEP_W + 2,
    parameter int ID_W    = (NCH > 2) ? $clog2(NCH) : 1,
    parameter int TIMEOUT = 1024
)(
    input  logic                  clk156,
    input  logic                  sys_rst,
    output logic [NCH-1:0]        fifo_rd_en,
    input  logic [NCH*ENT_W-1:0]  fifo_dout,
    input  logic [NCH-1:0]        fifo_empty,
    output logic                  wr_en,
    output logic [ENT_W+ID_W-1:0] din,
    input  logic                  full,
    output logic                  timeout_pulse,
    output logic [NCH*32-1:0]     pkt_cnt
);

    localparam int LAST_B = last_bit(DATA_W);
    localparam int CNT_W  = $clog2(TIMEOUT + 2);

    txarb_state_t    state_q, state_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] idle_q, idle_d;

    logic [ENT_W-1:0] ent [NCH];
    logic [ENT_W-1:0] cur_ent;
    logic             cur_empty;
    logic [ID_W-1:0]  pick;
    logic             found;

    for (genvar i = 0; i < NCH; i++) begin : g_ent
        assign ent[i] = fifo_dout[i*ENT_W +: ENT_W];
    end

    assign cur_ent   = ent[grant_q];
    assign cur_empty = fifo_empty[grant_q];

    eth_rr_pick #(.NCH(NCH), .ID_W(ID_W)) u_pick (
        .req   (~fifo_empty),
        .ptr   (ptr_q),
        .grant (pick),
        .found (found)
    );

    // Next-state, grant/pointer update and the combinational beat path.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        ptr_d         = ptr_q;
        idle_d        = idle_q;
        fifo_rd_en    = '0;
        wr_en         = 1'b0;
        din           = '0;
        timeout_pulse = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d = pick;
                    idle_d  = '0;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (!cur_empty) begin
                    if (!full) begin
                        fifo_rd_en[grant_q] = 1'b1;
                        wr_en  = 1'b1;
                        din    = {grant_q, cur_ent};
                        idle_d = '0;
                        if (cur_ent[LAST_B]) begin
                            ptr_d   = grant_q;
                            state_d = ST_IDLE;
                        end
                    end
                end else if (TIMEOUT != 0 && !full) begin
                    if (idle_q == CNT_W'(TIMEOUT)) begin
                        wr_en = 1'b1;
                        din   = {grant_q, TERM_UL,
                                 {KEEP_W{1'b0}}, {DATA_W{1'b0}}};
                        timeout_pulse = 1'b1;
                        idle_d  = '0;
                        state_d = ST_FLUSH;
                    end else begin
                        idle_d = idle_q + CNT_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                if (!cur_empty) begin
                    fifo_rd_en[grant_q] = 1'b1;
                    if (cur_ent[LAST_B]) begin
                        ptr_d   = grant_q;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Arbiter state registers; ptr starts at NCH-1 so channel 0 wins first.
    always_ff @(posedge clk156 or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= ID_W'(NCH - 1);
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            idle_q  <= idle_d;
        end
    end

`ifdef TXARB_STATS_EN
    logic [NCH-1:0][31:0] cnt_q, cnt_d;

    // Count every written beat carrying last, terminators included.
    always_comb begin
        cnt_d = cnt_q;
        if (wr_en && din[LAST_B])
            cnt_d[grant_q] = cnt_q[grant_q] + 32'd1;
    end

    // Packet counter registers.
    always_ff @(posedge clk156 or posedge sys_rst) begin
        if (sys_rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign pkt_cnt = cnt_q;
`else
    assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_eth_txarb_n.sv
// Scoreboard bench for eth_txarb_n: FWFT FIFO models feed the DUT,
// a negedge monitor pops expected beats whenever wr_en is seen.
module tb_eth_txarb_n;

    localparam int NCH     = 4;
    localparam int DATA_W  = 64;
    localparam int KEEP_W  = 8;
    localparam int ENT_W   = DATA_W + KEEP_W + 2;
    localparam int ID_W    = 2;
    localparam int OUT_W   = ENT_W + ID_W;
    localparam int TIMEOUT = 8;
    localparam int DEPTH   = 64;

    logic                 clk156 = 1'b0;
    logic                 sys_rst = 1'b1;
    logic [NCH-1:0]       fifo_rd_en;
    logic [NCH*ENT_W-1:0] fifo_dout;
    logic [NCH-1:0]       fifo_empty;
    logic                 wr_en;
    logic [OUT_W-1:0]     din;
    logic                 full = 1'b0;
    logic                 timeout_pulse;
    logic [NCH*32-1:0]    pkt_cnt;

    always #5 clk156 = ~clk156;

    eth_txarb_n #(
        .NCH(NCH), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk156        (clk156),
        .sys_rst       (sys_rst),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_dout     (fifo_dout),
        .fifo_empty    (fifo_empty),
        .wr_en         (wr_en),
        .din           (din),
        .full          (full),
        .timeout_pulse (timeout_pulse),
        .pkt_cnt       (pkt_cnt)
    );

    logic [ENT_W-1:0] mem [NCH][DEPTH];
    int wp [NCH];
    int rp [NCH];
    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int n_pulse = 0;
    bit mon_en = 1'b1;
    logic [OUT_W-1:0] exp_q [$];
    int wr_cyc [$];

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            fifo_empty[i] = (wp[i] == rp[i]);
            fifo_dout[i*ENT_W +: ENT_W] = mem[i][rp[i] % DEPTH];
        end
    end

    always @(posedge clk156) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NCH; i++) begin
            if (sys_rst)
                rp[i] <= wp[i];
            else if (fifo_rd_en[i] && rp[i] != wp[i])
                rp[i] <= rp[i] + 1;
        end
    end

    task automatic check(string nm, logic [127:0] act, logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s got=%0h required=%0h", nm, act, req);
        end
    endtask

    always @(negedge clk156) begin
        logic [OUT_W-1:0] e;
        if (mon_en) begin
            if (|fifo_rd_en)
                check("rd_onehot", $countones(fifo_rd_en), 1);
            if (timeout_pulse)
                n_pulse++;
            if (wr_en) begin
                wr_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write got=%0h required=none",
                             din);
                end else begin
                    e = exp_q.pop_front();
                    check("din", din, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk156);
        #1;
    endtask

    function automatic logic [ENT_W-1:0] ent(int ch, int id, int b, int nb);
        logic       lst;
        logic [7:0] kp;
        logic [63:0] d;
        lst = (b == nb - 1);
        kp  = lst ? 8'h0F : 8'hFF;
        d   = 64'hA500_0000_0000_0000 | (64'(ch) << 40)
            | (64'(id) << 16) | 64'(b);
        return {1'b0, lst, kp, d};
    endfunction

    task automatic put(int ch, logic [ENT_W-1:0] e);
        mem[ch][wp[ch] % DEPTH] = e;
        wp[ch]++;
    endtask

    task automatic exp_pkt(int ch, int id, int nb);
        for (int b = 0; b < nb; b++)
            exp_q.push_back({ID_W'(ch), ent(ch, id, b, nb)});
    endtask

    task automatic pkt(int ch, int id, int nb, bit ex);
        for (int b = 0; b < nb; b++)
            put(ch, ent(ch, id, b, nb));
        if (ex)
            exp_pkt(ch, id, nb);
    endtask

    task automatic drain(string nm);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            tick();
            k++;
        end
        repeat (4) tick();
        check({nm, "_drain"}, exp_q.size(), 0);
    endtask

    initial begin
        int k;
        logic [ENT_W-1:0] term;
        logic [31:0] exp_cnt;
        term = {2'b11, 8'h00, 64'h0};
        for (int i = 0; i < NCH; i++)
            wp[i] = 0;
        repeat (3) tick();
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_din", din, 0);
        check("rst_tpulse", timeout_pulse, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        sys_rst = 1'b0;
        tick();

        // round robin over four 3-beat packets
        wr_cyc.delete();
        for (int ch = 0; ch < NCH; ch++)
            pkt(ch, 1, 3, 1'b1);
        drain("t1");
        check("t1_nwr", wr_cyc.size(), 12);
        if (wr_cyc.size() == 12)
            for (int i = 1; i < 12; i++)
                check("t1_gap", wr_cyc[i] - wr_cyc[i-1], (i % 3 == 0) ? 2 : 1);

        // no interleave; ch2 served between ch1 packets
        wr_cyc.delete();
        pkt(1, 2, 6, 1'b1);
        pkt(1, 3, 2, 1'b0);
        repeat (3) tick();
        pkt(2, 2, 3, 1'b1);
        exp_pkt(1, 3, 2);
        drain("t2");
        check("t2_nwr", wr_cyc.size(), 11);
        if (wr_cyc.size() == 11)
            check("t2_gap", wr_cyc[6] - wr_cyc[5], 2);

        // full held mid-packet
        pkt(3, 4, 4, 1'b1);
        tick();
        tick();
        full = 1'b1;
        repeat (5) begin
            @(negedge clk156);
            check("t3_full_wr", wr_en, 0);
            check("t3_full_rd", fifo_rd_en, 0);
            tick();
        end
        full = 1'b0;
        drain("t3");

        // watchdog on stalled ch0
        wr_cyc.delete();
        n_pulse = 0;
        put(0, ent(0, 5, 0, 4));
        put(0, ent(0, 5, 1, 4));
        exp_q.push_back({2'd0, ent(0, 5, 0, 4)});
        exp_q.push_back({2'd0, ent(0, 5, 1, 4)});
        exp_q.push_back({2'd0, term});
        k = 0;
        while (n_pulse == 0 && k < 40) begin
            tick();
            k++;
        end
        check("t4_pulse", n_pulse, 1);
        check("t4_nwr", wr_cyc.size(), 3);
        if (wr_cyc.size() == 3)
            check("t4_gap", wr_cyc[2] - wr_cyc[1], TIMEOUT + 1);
        put(0, ent(0, 5, 2, 4));
        put(0, ent(0, 5, 3, 4));
        pkt(0, 7, 2, 1'b0);
        pkt(1, 6, 2, 1'b1);
        exp_pkt(0, 7, 2);
        drain("t4");
        check("t4_pulse_once", n_pulse, 1);

        // reset mid-packet
        mon_en = 1'b0;
        pkt(2, 8, 4, 1'b0);
        tick();
        tick();
        check("t5_mid_wr", wr_en, 1);
        sys_rst = 1'b1;
        #1;
        check("t5_rst_wr", wr_en, 0);
        check("t5_rst_rd", fifo_rd_en, 0);
        check("t5_rst_din", din, 0);
        check("t5_rst_tp", timeout_pulse, 0);
        check("t5_rst_cnt", pkt_cnt, 0);
        tick();
        tick();
        sys_rst = 1'b0;
        mon_en = 1'b1;
        pkt(2, 9, 2, 1'b0);
        pkt(0, 9, 2, 1'b1);
        exp_pkt(2, 9, 2);
        drain("t5");

        // stats: five packets on ch3
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        tick();
        for (int p = 0; p < 5; p++)
            pkt(3, 10 + p, 2, 1'b1);
        drain("t6");
        for (int ch = 0; ch < NCH; ch++) begin
`ifdef TXARB_STATS_EN
            exp_cnt = (ch == 3) ? 32'd5 : 32'd0;
`else
            exp_cnt = 32'd0;
`endif
            check("t6_pkt_cnt", pkt_cnt[ch*32 +: 32], exp_cnt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_txarb_n.md
# eth_txarb_n

N-channel, packet-atomic round-robin merger in the clk156 domain. It reads the per-tap PCIe-to-Ethernet FIFOs and writes one channel-tagged beat stream into the arbiter-to-encap FIFO. It generalises the two-input arbiter in channel count and data width. It adds a stalled-packet watchdog that terminates and flushes a packet whose source FIFO runs dry mid-packet.

## Interface
- NCH, 2: number of input channels, 2..16.
- DATA_W, 64: data bits per beat.
- KEEP_W, DATA_W/8: byte-enable bits.
- ENT_W, DATA_W+KEEP_W+2: FIFO entry width. Layout is {user, last, keep, data}: data [DATA_W-1:0], keep above it, then last, then user at MSB.
- ID_W, max(1,$clog2(NCH)): channel tag width.
- TIMEOUT, 1024: mid-packet empty cycles before the watchdog fires. 0 disables the watchdog.

Ports:
- clk156  in  1  sole clock.
- sys_rst  in  1  reset, asynchronous, active-high.
- fifo_rd_en  out  NCH  per-channel read strobe to FWFT input FIFOs.
- fifo_dout  in  NCH*ENT_W  packed entries; channel i at [i*ENT_W +: ENT_W]. Valid whenever !fifo_empty[i].
- fifo_empty  in  NCH  per-channel empty.
- wr_en  out  1  write strobe to output FIFO.
- din  out  ENT_W+ID_W  {channel id, entry}.
- full  in  1  output FIFO full.
- timeout_pulse  out  1  one-cycle pulse when the watchdog terminates a packet.
- pkt_cnt  out  NCH*32  per-channel count of packets written.

## Operation
- States: IDLE, XFER, FLUSH. Registers: state, grant (ID_W), last-served pointer ptr, idle counter.
- IDLE: search channels ptr+1, ptr+2, … with wrap modulo NCH. The first with !fifo_empty becomes grant; go to XFER. If nothing is requested, stay in IDLE.
- XFER: when !fifo_empty[grant] && !full, beat = 1:
  - fifo_rd_en[grant]=1, wr_en=1, din={grant, fifo_dout[grant]}, same cycle.
  - A beat with last=1 sets ptr<=grant and returns to IDLE.
- XFER with fifo_empty[grant]: the idle counter increments. A transferred beat clears it. full holds the counter unchanged.
- Watchdog: when the counter reaches TIMEOUT and !full, write a synthetic beat {grant, user=1, last=1, keep=0, data=0} with rd_en low, pulse timeout_pulse, and go to FLUSH.
- FLUSH: fifo_rd_en[grant]=!fifo_empty[grant], wr_en=0. Discard beats until one with last=1 is read, then set ptr<=grant and go to IDLE.
- Only one bit of fifo_rd_en is ever high. Non-granted channels are never read.
- Arbitration is packet-atomic: a granted channel keeps the grant until its last beat or until the flush completes.

## Timing
- Data path is combinational from the FWFT dout to din. Zero-cycle latency, no overflow because full is checked in the same cycle.
- Grant takes one IDLE cycle per packet: IDLE→XFER costs one bubble. Back-to-back beats within a packet run at 1/cycle.
- Reset values: state=IDLE, ptr=NCH-1 (channel 0 first), grant=0, counter=0, all counters 0. Outputs: fifo_rd_en=0, wr_en=0, din=0, timeout_pulse=0.
- Reset asserted mid-packet: the packet is abandoned with no terminator. Downstream FIFOs share sys_rst.
- ptr wraps NCH-1→0. NCH that is not a power of 2 skips unused ids.
- Simultaneous full and timeout: the synthetic beat is deferred until !full.
- Watchdog does not run in IDLE or FLUSH.

## Configuration
- TXARB_STATS_EN defined: pkt_cnt[i] increments, wrapping at 2^32, on every written beat with last=1 on channel i. Synthetic terminators count.
- TXARB_STATS_EN undefined: pkt_cnt is tied to 0 and no counter logic is built. timeout_pulse is still present.

## Structure
- Package eth_pkg holds:
  - entry field offsets (DATA_LSB, KEEP_LSB, LAST_BIT, USER_BIT) as functions of DATA_W;
  - the state enum txarb_state_t;
  - the synthetic-terminator constant.
- Sub-module eth_rr_pick: combinational round-robin priority picker (req, ptr → grant, found).

## Test plan
- NCH=4, each channel holds one 3-beat packet → 12 beats out in channel order 0,1,2,3. Tags match. One bubble between packets.
- Channel 1 streams continuously, channel 2 posts a packet mid-packet of channel 1 → no interleave. Channel 2 is served right after channel 1's last beat.
- full held high for 5 cycles mid-packet → wr_en and rd_en stay 0. Transfer resumes with no lost or duplicated beat.
- TIMEOUT=8, channel 0 writes 2 beats then stalls 8 cycles → synthetic beat {0, user=1, last=1, keep=0} and timeout_pulse. The late remaining beats are discarded through last. Channel 1 is served next.
- sys_rst pulsed mid-packet → all outputs 0 immediately. After release, channel 0 has priority.
- With TXARB_STATS_EN, 5 packets on channel 3 → pkt_cnt[3]=5, others 0.
